// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: ALU has default priority, memory
// writes use valid/ready and are forced through after STARVE_LIMIT blocked cycles.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_reg,
    input  logic [31:0] alu_wb_data,
    output logic        alu_stall,
    input  logic        mem_wb_valid,
    input  logic [4:0]  mem_wb_reg,
    input  logic [31:0] mem_wb_data,
    output logic        mem_wb_ready,
    output logic        reg_write,
    output logic [4:0]  reg_to_write,
    output logic [31:0] write_data
);

    typedef enum logic {NORMAL, FORCE} state_t;

    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    state_t     state, state_next;
    logic [7:0] starve_cnt, starve_next;
    logic       collision;
    logic       alu_accept;
    logic       mem_accept;
    logic       mem_blocked;

    // The load is older than the ALU result, so a same-register clash must let memory go first.
    assign collision = alu_wb_valid && mem_wb_valid
                    && (mem_wb_reg == alu_wb_reg) && (alu_wb_reg != 5'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        case (state)
            NORMAL: begin
                if (mem_blocked) begin
                    if (starve_cnt == LIMIT_M1) begin
                        state_next  = FORCE;
                        starve_next = 8'd0;
                    end else begin
                        starve_next = starve_cnt + 8'd1;
                    end
                end else begin
                    starve_next = 8'd0;
                end
            end
            FORCE: begin
                // Either the forced grant completes or memory dropped its request; both end FORCE.
                state_next  = NORMAL;
                starve_next = 8'd0;
            end
            default: begin
                state_next  = NORMAL;
                starve_next = 8'd0;
            end
        endcase
    end

    always_comb begin
        alu_stall    = 1'b0;
        mem_wb_ready = 1'b0;
        if (!reset) begin
            case (state)
                NORMAL: begin
                    if (collision) begin
                        mem_wb_ready = 1'b1;
                        alu_stall    = 1'b1;
                    end else if (!alu_wb_valid) begin
                        mem_wb_ready = mem_wb_valid;
                    end
                end
                FORCE: begin
                    mem_wb_ready = 1'b1;
                    alu_stall    = alu_wb_valid && mem_wb_valid;
                end
                default: begin
                    alu_stall    = 1'b0;
                    mem_wb_ready = 1'b0;
                end
            endcase
        end
    end

    assign mem_accept  = mem_wb_valid && mem_wb_ready;
    assign alu_accept  = alu_wb_valid && !alu_stall && !reset;
    assign mem_blocked = mem_wb_valid && !mem_wb_ready;

    // Memory and ALU acceptance are mutually exclusive; the mux keeps a single source per write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write    <= 1'b0;
            reg_to_write <= 5'd0;
            write_data   <= 32'd0;
        end else if (mem_accept) begin
            reg_write    <= (mem_wb_reg != 5'd0);
            reg_to_write <= mem_wb_reg;
            write_data   <= mem_wb_data;
        end else if (alu_accept) begin
            reg_write    <= (alu_wb_reg != 5'd0);
            reg_to_write <= alu_wb_reg;
            write_data   <= alu_wb_data;
        end else begin
            reg_write    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized
// traffic checked against a queue-level arbitration and register-file model.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_reg;
    logic [31:0] alu_wb_data;
    logic        alu_stall;
    logic        mem_wb_valid;
    logic [4:0]  mem_wb_reg;
    logic [31:0] mem_wb_data;
    logic        mem_wb_ready;
    logic        reg_write;
    logic [4:0]  reg_to_write;
    logic [31:0] write_data;

    int checks = 0;
    int passed = 0;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .alu_wb_valid(alu_wb_valid),
        .alu_wb_reg(alu_wb_reg),
        .alu_wb_data(alu_wb_data),
        .alu_stall(alu_stall),
        .mem_wb_valid(mem_wb_valid),
        .mem_wb_reg(mem_wb_reg),
        .mem_wb_data(mem_wb_data),
        .mem_wb_ready(mem_wb_ready),
        .reg_write(reg_write),
        .reg_to_write(reg_to_write),
        .write_data(write_data)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        alu_wb_valid = av;
        alu_wb_reg   = ar;
        alu_wb_data  = ad;
        mem_wb_valid = mv;
        mem_wb_reg   = mr;
        mem_wb_data  = md;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'h000000A5, 1'b1, 5'd6, 32'h00000066);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready, reg_write} !== 3'b000)
            $display("FAIL reset_hs: stall/ready/write=%b want 000", {alu_stall, mem_wb_ready, reg_write});
        else passed++;
        tick();
        tick();
        checks++;
        if ({alu_stall, mem_wb_ready, reg_write, reg_to_write, write_data} !== {3'b000, 5'd0, 32'd0})
            $display("FAIL reset_held: got %b %0d %h want 000 0 0",
                     {alu_stall, mem_wb_ready, reg_write}, reg_to_write, write_data);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b00)
            $display("FAIL reset_release_hs: stall/ready=%b want 00", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        checks++;
        if ({reg_write, reg_to_write, write_data} !== {1'b1, 5'd5, 32'h000000A5})
            $display("FAIL reset_alu_first: got %b %0d %h want 1 5 000000a5", reg_write, reg_to_write, write_data);
        else passed++;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h00000066);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b01)
            $display("FAIL reset_mem_hs: stall/ready=%b want 01", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        checks++;
        if ({reg_write, reg_to_write, write_data} !== {1'b1, 5'd6, 32'h00000066})
            $display("FAIL reset_mem_write: got %b %0d %h want 1 6 00000066", reg_write, reg_to_write, write_data);
        else passed++;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if ({reg_write, reg_to_write, write_data} !== {1'b0, 5'd6, 32'h00000066})
            $display("FAIL idle_hold: got %b %0d %h want 0 6 00000066", reg_write, reg_to_write, write_data);
        else passed++;
    endtask

    task automatic test_alu_then_mem();
        drive(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b00)
            $display("FAIL seq_alu_hs: stall/ready=%b want 00", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        checks++;
        if ({reg_write, reg_to_write, write_data} !== {1'b1, 5'd3, 32'h11111111})
            $display("FAIL seq_alu_write: got %b %0d %h want 1 3 11111111", reg_write, reg_to_write, write_data);
        else passed++;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hDEADBEEF);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b01)
            $display("FAIL seq_mem_hs: stall/ready=%b want 01", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        checks++;
        if ({reg_write, reg_to_write, write_data} !== {1'b1, 5'd4, 32'hDEADBEEF})
            $display("FAIL seq_mem_write: got %b %0d %h want 1 4 deadbeef", reg_write, reg_to_write, write_data);
        else passed++;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_starvation();
        int a;
        a = 1;
        for (int k = 0; k < 10; k++) begin
            logic [1:0]  exp_hs;
            logic [4:0]  exp_reg;
            logic [31:0] exp_data;
            drive(1'b1, 5'(a), 32'(a * 16), (k <= LIMIT), 5'd20, 32'hCAFEF00D);
            #1;
            if (k == LIMIT) begin
                exp_hs = 2'b11; exp_reg = 5'd20; exp_data = 32'hCAFEF00D;
            end else begin
                exp_hs = 2'b00; exp_reg = 5'(a); exp_data = 32'(a * 16);
            end
            checks++;
            if ({alu_stall, mem_wb_ready} !== exp_hs)
                $display("FAIL starve_hs[%0d]: stall/ready=%b want %b", k, {alu_stall, mem_wb_ready}, exp_hs);
            else passed++;
            tick();
            checks++;
            if ({reg_write, reg_to_write, write_data} !== {1'b1, exp_reg, exp_data})
                $display("FAIL starve_write[%0d]: got %b %0d %h want 1 %0d %h",
                         k, reg_write, reg_to_write, write_data, exp_reg, exp_data);
            else passed++;
            if (k != LIMIT) a++;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_collision();
        logic [31:0] r7;
        r7 = 32'hFFFF_0000;
        drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b11)
            $display("FAIL coll_hs: stall/ready=%b want 11", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        if (reg_write && reg_to_write == 5'd7) r7 = write_data;
        checks++;
        if ({reg_write, reg_to_write, write_data} !== {1'b1, 5'd7, 32'h2})
            $display("FAIL coll_mem_first: got %b %0d %h want 1 7 00000002", reg_write, reg_to_write, write_data);
        else passed++;
        drive(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b00)
            $display("FAIL coll_alu_hs: stall/ready=%b want 00", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        if (reg_write && reg_to_write == 5'd7) r7 = write_data;
        checks++;
        if ({reg_write, reg_to_write, write_data} !== {1'b1, 5'd7, 32'h1})
            $display("FAIL coll_alu_second: got %b %0d %h want 1 7 00000001", reg_write, reg_to_write, write_data);
        else passed++;
        checks++;
        if (r7 !== 32'h1)
            $display("FAIL coll_final_r7: got %h want 00000001", r7);
        else passed++;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_r0();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b00)
            $display("FAIL r0_alu_hs: stall/ready=%b want 00", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        checks++;
        if (reg_write !== 1'b0) $display("FAIL r0_alu_write: reg_write=%b want 0", reg_write);
        else passed++;
        // Both target r0: no collision, so the ALU goes and memory waits.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h12345678);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b00)
            $display("FAIL r0_both_hs: stall/ready=%b want 00", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        // Memory r0 blocked a further 2 cycles (3 in total) before being accepted.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 5'(k + 1), 32'(k), 1'b1, 5'd0, 32'h12345678);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678);
        #1;
        checks++;
        if ({alu_stall, mem_wb_ready} !== 2'b01)
            $display("FAIL r0_mem_hs: stall/ready=%b want 01", {alu_stall, mem_wb_ready});
        else passed++;
        tick();
        checks++;
        if (reg_write !== 1'b0) $display("FAIL r0_mem_write: reg_write=%b want 0", reg_write);
        else passed++;
        // The r0 acceptance cleared the starvation count: a new request waits a full LIMIT cycles.
        for (int k = 0; k <= LIMIT; k++) begin
            drive(1'b1, 5'(k + 10), 32'(k), 1'b1, 5'd9, 32'h99999999);
            #1;
            checks++;
            if (mem_wb_ready !== (k == LIMIT))
                $display("FAIL r0_starve_clear[%0d]: mem_wb_ready=%b want %b", k, mem_wb_ready, (k == LIMIT));
            else passed++;
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_reset_in_force();
        for (int k = 0; k < LIMIT; k++) begin
            drive(1'b1, 5'(k + 1), 32'(k + 100), 1'b1, 5'd21, 32'hBADC0DE5);
            tick();
        end
        // Now in FORCE with the last ALU write still on the outputs.
        checks++;
        if ({reg_write, mem_wb_ready} !== 2'b11)
            $display("FAIL force_entry: write/ready=%b want 11", {reg_write, mem_wb_ready});
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if ({reg_write, alu_stall, mem_wb_ready} !== 3'b000)
            $display("FAIL force_reset_async: write/stall/ready=%b want 000", {reg_write, alu_stall, mem_wb_ready});
        else passed++;
        tick();
        checks++;
        if (reg_write !== 1'b0) $display("FAIL force_reset_no_write: reg_write=%b want 0", reg_write);
        else passed++;
        reset = 1'b0;
        for (int k = 0; k <= LIMIT; k++) begin
            logic [4:0]  exp_reg;
            logic [31:0] exp_data;
            drive(1'b1, 5'(k + 5), 32'(k + 200), 1'b1, 5'd21, 32'hBADC0DE5);
            #1;
            checks++;
            if (mem_wb_ready !== (k == LIMIT))
                $display("FAIL force_discarded[%0d]: mem_wb_ready=%b want %b", k, mem_wb_ready, (k == LIMIT));
            else passed++;
            exp_reg  = (k == LIMIT) ? 5'd21 : 5'(k + 5);
            exp_data = (k == LIMIT) ? 32'hBADC0DE5 : 32'(k + 200);
            tick();
            checks++;
            if ({reg_write, reg_to_write, write_data} !== {1'b1, exp_reg, exp_data})
                $display("FAIL post_reset_write[%0d]: got %b %0d %h want 1 %0d %h",
                         k, reg_write, reg_to_write, write_data, exp_reg, exp_data);
            else passed++;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    typedef struct {
        bit          valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } req_t;

    task automatic test_random();
        req_t        alu_q, mem_q;
        logic [31:0] model_rf [32];
        logic [31:0] seen_rf [32];
        int          wait_cycles;
        bit          forced;
        int          acc;
        bit          exp_stall, exp_ready, exp_rw;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        alu_q = '{default: '0};
        mem_q = '{default: '0};
        wait_cycles = 0;
        forced = 1'b0;
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            seen_rf[i]  = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!alu_q.valid && ($urandom_range(0, 9) < 7))
                alu_q = '{1'b1, 5'($urandom_range(0, 31)), $urandom};
            if (!mem_q.valid && ($urandom_range(0, 9) < 4)) begin
                mem_q = '{1'b1, 5'($urandom_range(0, 31)), $urandom};
                if (alu_q.valid && ($urandom_range(0, 3) == 0)) mem_q.rd = alu_q.rd;
            end
            drive(alu_q.valid, alu_q.rd, alu_q.data, mem_q.valid, mem_q.rd, mem_q.data);
            // 0 = none, 1 = ALU, 2 = memory
            if (alu_q.valid && mem_q.valid && alu_q.rd == mem_q.rd && alu_q.rd != 0) acc = 2;
            else if (forced && mem_q.valid) acc = 2;
            else if (alu_q.valid) acc = 1;
            else if (mem_q.valid) acc = 2;
            else acc = 0;
            exp_stall = alu_q.valid && (acc != 1);
            exp_ready = forced || (acc == 2);
            #1;
            checks++;
            if ({alu_stall, mem_wb_ready} !== {exp_stall, exp_ready})
                $display("FAIL rand_hs[%0d]: stall/ready=%b want %b", cyc, {alu_stall, mem_wb_ready},
                         {exp_stall, exp_ready});
            else passed++;
            exp_rw = 1'b0; exp_reg = '0; exp_data = '0;
            if (acc == 1) begin
                exp_rw = (alu_q.rd != 0); exp_reg = alu_q.rd; exp_data = alu_q.data;
                alu_q.valid = 1'b0;
            end else if (acc == 2) begin
                exp_rw = (mem_q.rd != 0); exp_reg = mem_q.rd; exp_data = mem_q.data;
                mem_q.valid = 1'b0;
            end
            if (mem_q.valid) begin
                wait_cycles++;
                if (wait_cycles == LIMIT) begin
                    forced = 1'b1;
                    wait_cycles = 0;
                end
            end else begin
                wait_cycles = 0;
                forced = 1'b0;
            end
            if (exp_rw) model_rf[exp_reg] = exp_data;
            tick();
            if (reg_write === 1'b1) seen_rf[reg_to_write] = write_data;
            checks++;
            if (exp_rw ? ({reg_write, reg_to_write, write_data} !== {1'b1, exp_reg, exp_data})
                       : (reg_write !== 1'b0))
                $display("FAIL rand_write[%0d]: got %b %0d %h want %b %0d %h", cyc,
                         reg_write, reg_to_write, write_data, exp_rw, exp_reg, exp_data);
            else passed++;
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (seen_rf[i] !== model_rf[i])
                $display("FAIL rand_rf[%0d]: got %h want %h", i, seen_rf[i], model_rf[i]);
            else passed++;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_then_mem();
        test_starvation();
        test_collision();
        test_r0();
        test_reset_in_force();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
